axi_master_port: RTL

AXI_MASTER_PORT -- requirements
Module: axi_master_port

---
 rtl/axi_master_port_if.sv | 83 ++++++++
 rtl/axi_master_port.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/axi_master_port_if.sv
// Bundles the request-side and AXI4 master-side signals of axi_master_port.
// master modport: the port engine's view; slave modport: the environment's view.
// Widths follow the AXI ID/DATA/ADDR parameters; strobe width is DATA/8.
interface axi_master_port_if #(
    parameter int C_M_AXI_ID_WIDTH   = 4,
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int C_M_AXI_ADDR_WIDTH = 32
);
    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    // request / user data side
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_write;
    logic [C_M_AXI_ADDR_WIDTH-1:0] req_addr;
    logic [7:0]                    req_len;
    logic                          wd_valid;
    logic                          wd_ready;
    logic [C_M_AXI_DATA_WIDTH-1:0] wd_data;
    logic [STRB_W-1:0]             wd_strb;
    logic                          rd_valid;
    logic                          rd_ready;
    logic [C_M_AXI_DATA_WIDTH-1:0] rd_data;
    logic                          rd_last;
    logic                          done;
    logic [1:0]                    done_resp;
    logic                          chk_err;

    // AXI write address / data / response
    logic                          M_AXI_AWVALID;
    logic                          M_AXI_AWREADY;
    logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_AWID;
    logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
    logic [7:0]                    M_AXI_AWLEN;
    logic [2:0]                    M_AXI_AWSIZE;
    logic [1:0]                    M_AXI_AWBURST;
    logic                          M_AXI_WVALID;
    logic                          M_AXI_WREADY;
    logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA;
    logic [STRB_W-1:0]             M_AXI_WSTRB;
    logic                          M_AXI_WLAST;
    logic                          M_AXI_BVALID;
    logic                          M_AXI_BREADY;
    logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_BID;
    logic [1:0]                    M_AXI_BRESP;

    // AXI read address / data
    logic                          M_AXI_ARVALID;
    logic                          M_AXI_ARREADY;
    logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID;
    logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [7:0]                    M_AXI_ARLEN;
    logic [2:0]                    M_AXI_ARSIZE;
    logic [1:0]                    M_AXI_ARBURST;
    logic                          M_AXI_RVALID;
    logic                          M_AXI_RREADY;
    logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID;
    logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]                    M_AXI_RRESP;
    logic                          M_AXI_RLAST;

    modport master (
        input  req_valid, req_write, req_addr, req_len, wd_valid, wd_data, wd_strb, rd_ready,
               M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BID, M_AXI_BRESP,
               M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
        output req_ready, wd_ready, rd_valid, rd_data, rd_last, done, done_resp, chk_err,
               M_AXI_AWVALID, M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
               M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_BREADY,
               M_AXI_ARVALID, M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
               M_AXI_RREADY
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, wd_valid, wd_data, wd_strb, rd_ready,
               M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BID, M_AXI_BRESP,
               M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
        input  req_ready, wd_ready, rd_valid, rd_data, rd_last, done, done_resp, chk_err,
               M_AXI_AWVALID, M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
               M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_BREADY,
               M_AXI_ARVALID, M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
               M_AXI_RREADY
    );
endinterface

// File: rtl/axi_master_port.sv
// Single-outstanding AXI4 INCR burst master: one request -> one AR/R or AW/W/B burst.
// Latency: AxVALID one cycle after request accept; done pulses one cycle after last R / B handshake.
// Backpressure: R/W beats pass straight through (rd_ready->RREADY, WREADY->wd_ready); one burst in flight.
// Optional protocol checker (ID, RLAST position) enabled by defining AXI_MASTER_CHK_EN.
module axi_master_port #(
    parameter int C_M_AXI_ID_WIDTH   = 4,
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int C_M_AXI_ADDR_WIDTH = 32
) (
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESETN,
    axi_master_port_if.master bus
);
    localparam logic [2:0] AXSIZE = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } state_t;

    state_t                        state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                    len_q, len_d;
    logic                          write_q, write_d;
    // 9 bits so a 256-beat burst can count its final beat without wrapping
    logic [8:0]                    cnt_q, cnt_d;
    logic [1:0]                    rresp_q, rresp_d;
    logic                          done_q, done_d;
    logic [1:0]                    done_resp_q, done_resp_d;

    logic       in_r, in_w;
    logic       r_hs, w_hs;
    logic       at_last;
    logic [1:0] rresp_max;
    logic [1:0] fin_resp;

    assign in_r      = (state_q == ST_R);
    assign in_w      = (state_q == ST_W);
    assign r_hs      = in_r && bus.M_AXI_RVALID && bus.rd_ready;
    assign w_hs      = in_w && bus.wd_valid && bus.M_AXI_WREADY;
    assign at_last   = (cnt_q == {1'b0, len_q});
    assign rresp_max = (bus.M_AXI_RRESP > rresp_q) ? bus.M_AXI_RRESP : rresp_q;
    // completion response: B response for writes, worst read response for reads
    assign fin_resp  = write_q ? bus.M_AXI_BRESP : rresp_max;

    // next-state, latched request fields, beat counter and completion pulse
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        rresp_d     = rresp_q;
        done_d      = 1'b0;
        done_resp_d = done_resp_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    len_d   = bus.req_len;
                    write_d = bus.req_write;
                    cnt_d   = '0;
                    rresp_d = 2'b00;
                    state_d = bus.req_write ? ST_AW : ST_AR;
                end
            end
            ST_AR: begin
                if (bus.M_AXI_ARREADY) state_d = ST_R;
            end
            ST_R: begin
                if (r_hs) begin
                    cnt_d   = cnt_q + 9'd1;
                    rresp_d = rresp_max;
                    // the slave's RLAST, not our beat count, ends the burst
                    if (bus.M_AXI_RLAST) begin
                        state_d     = ST_IDLE;
                        done_d      = 1'b1;
                        done_resp_d = fin_resp;
                    end
                end
            end
            ST_AW: begin
                if (bus.M_AXI_AWREADY) state_d = ST_W;
            end
            ST_W: begin
                if (w_hs) begin
                    cnt_d = cnt_q + 9'd1;
                    if (at_last) state_d = ST_B;
                end
            end
            ST_B: begin
                if (bus.M_AXI_BVALID) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    done_resp_d = fin_resp;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and burst context registers; reset abandons any burst in flight
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            rresp_q     <= 2'b00;
            done_q      <= 1'b0;
            done_resp_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            rresp_q     <= rresp_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
        end
    end

    // request side
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.done      = done_q;
    assign bus.done_resp = done_resp_q;

    // address channels: fields come from the latched request, so they hold while VALID waits
    assign bus.M_AXI_ARVALID = (state_q == ST_AR);
    assign bus.M_AXI_ARID    = '0;
    assign bus.M_AXI_ARADDR  = addr_q;
    assign bus.M_AXI_ARLEN   = len_q;
    assign bus.M_AXI_ARSIZE  = AXSIZE;
    assign bus.M_AXI_ARBURST = 2'b01;
    assign bus.M_AXI_AWVALID = (state_q == ST_AW);
    assign bus.M_AXI_AWID    = '0;
    assign bus.M_AXI_AWADDR  = addr_q;
    assign bus.M_AXI_AWLEN   = len_q;
    assign bus.M_AXI_AWSIZE  = AXSIZE;
    assign bus.M_AXI_AWBURST = 2'b01;

    // read data pass-through, gated to the R phase
    assign bus.M_AXI_RREADY = in_r && bus.rd_ready;
    assign bus.rd_valid     = in_r && bus.M_AXI_RVALID;
    assign bus.rd_data      = bus.M_AXI_RDATA;
    assign bus.rd_last      = in_r && bus.M_AXI_RLAST;

    // write data pass-through, gated to the W phase (so no W before the AW handshake)
    assign bus.M_AXI_WVALID = in_w && bus.wd_valid;
    assign bus.wd_ready     = in_w && bus.M_AXI_WREADY;
    assign bus.M_AXI_WDATA  = bus.wd_data;
    assign bus.M_AXI_WSTRB  = bus.wd_strb;
    assign bus.M_AXI_WLAST  = in_w && at_last;
    assign bus.M_AXI_BREADY = (state_q == ST_B);

`ifdef AXI_MASTER_CHK_EN
    logic chk_err_q;
    logic chk_hit;

    // flag non-zero IDs and an RLAST that disagrees with the requested length
    always_comb begin
        chk_hit = 1'b0;
        if (r_hs) begin
            if (bus.M_AXI_RID != '0)            chk_hit = 1'b1;
            if (bus.M_AXI_RLAST && !at_last)    chk_hit = 1'b1;
            if (!bus.M_AXI_RLAST && at_last)    chk_hit = 1'b1;
        end
        if ((state_q == ST_B) && bus.M_AXI_BVALID && (bus.M_AXI_BID != '0)) chk_hit = 1'b1;
    end

    // sticky error flag, cleared only by reset
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) chk_err_q <= 1'b0;
        else                chk_err_q <= chk_err_q | chk_hit;
    end

    assign bus.chk_err = chk_err_q;
`else
    assign bus.chk_err = 1'b0;
`endif

endmodule
